// File: rtl/fft_frame_packer.sv
// ---------------------------------------------------------------------------
// fft_frame_packer
//
// Serial-to-parallel input stage for the 8-point FFT core. Signed samples
// arrive one per beat. Each group of eight consecutive samples is gathered
// into one frame. The frame is presented as eight parallel words, m_x0..m_x7,
// with m_x0 the oldest sample. Back-to-back frames stream at one sample per
// cycle with no bubbles, as long as the FFT core keeps accepting.
//
// Optional feature (macro FRAME_SYNC_EN):
//   When defined, this adds the s_last input and the frame_err output.
//   - s_last on a sample before the 8th closes the frame early. The
//     remaining slots are zero-filled and frame_err pulses.
//   - A missing s_last on the 8th sample also pulses frame_err.
//   When undefined, framing is purely by count of eight.
//
// Parameters:
//   DATA_W    sample width (signed two's complement), matches FFT input width
//   CNT_W     width of the emitted-frame counter
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   s_valid    input sample valid
//   s_ready    packer can accept a sample this cycle
//   s_data     signed input sample
//   s_last     end-of-frame marker (FRAME_SYNC_EN only)
//   m_valid    frame valid toward the FFT core
//   m_ready    FFT core accepts the frame
//   m_x0..m_x7 frame samples, m_x0 oldest
//   frame_cnt  frames transferred on the m side, wraps
//   frame_err  one-cycle framing error pulse (FRAME_SYNC_EN only)
//   dbg_idx    current fill index (write slot of the next sample)
//
// Handshake rule (both sides):
//   A beat transfers on the rising edge where valid && ready are both high.
//   A producer holding valid keeps its data stable until that edge.
//   s_ready never depends on s_valid. It is a function only of m_ready,
//   registered state and, with FRAME_SYNC_EN, the s_last qualifier.
// ---------------------------------------------------------------------------
module fft_frame_packer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
`ifdef FRAME_SYNC_EN
  input  logic                     s_last,
`endif
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_x0,
  output logic signed [DATA_W-1:0] m_x1,
  output logic signed [DATA_W-1:0] m_x2,
  output logic signed [DATA_W-1:0] m_x3,
  output logic signed [DATA_W-1:0] m_x4,
  output logic signed [DATA_W-1:0] m_x5,
  output logic signed [DATA_W-1:0] m_x6,
  output logic signed [DATA_W-1:0] m_x7,
  output logic [CNT_W-1:0]         frame_cnt,
`ifdef FRAME_SYNC_EN
  output logic                     frame_err,
`endif
  output logic [2:0]               dbg_idx
);

  localparam logic [2:0] IDX_LAST = 3'd7;

  logic [2:0]               idx;
  logic signed [DATA_W-1:0] fill   [0:6];
  logic signed [DATA_W-1:0] out_x  [0:7];
  logic signed [DATA_W-1:0] next_x [0:7];

  logic last_in;
  logic at_end;
  logic closes;
  logic accept;
  logic load;
  logic drain;

`ifdef FRAME_SYNC_EN
  assign last_in = s_last;
`else
  assign last_in = 1'b0;
`endif

  assign at_end = (idx == IDX_LAST);

  // A sample that closes a frame needs room in the output register.
  // The register is free when it is empty or is draining on this same edge.
  assign closes  = at_end || last_in;
  assign s_ready = !closes || !m_valid || m_ready;

  assign accept = s_valid && s_ready;
  assign load   = accept && closes;
  assign drain  = m_valid && m_ready;

  // Assemble the frame loaded on a closing beat:
  //   - slots below idx come from the fill buffer,
  //   - slot idx takes the incoming sample,
  //   - slots above idx are zero (early close only).
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      if (3'(k) < idx) begin
        next_x[k] = fill[k];
      end else if (3'(k) == idx) begin
        next_x[k] = s_data;
      end else begin
        next_x[k] = '0;
      end
    end
    next_x[7] = at_end ? s_data : '0;
  end

  // Fill index: the next free slot, returning to 0 whenever a frame closes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx + 3'd1;
    end
  end

  // Fill buffer. A closing beat bypasses the buffer straight into the
  // output register, so only non-closing beats are written here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 7; k++) begin
        fill[k] <= '0;
      end
    end else if (accept && !load) begin
      fill[idx] <= s_data;
    end
  end

  // Output register. A load takes priority over a drain on the same edge,
  // so m_valid stays high carrying the new frame with no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        out_x[k] <= '0;
      end
    end else if (load) begin
      m_valid <= 1'b1;
      for (int k = 0; k < 8; k++) begin
        out_x[k] <= next_x[k];
      end
    end else if (drain) begin
      m_valid <= 1'b0;
    end
  end

  // Frame counter: counts m-side transfers and wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (drain) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef FRAME_SYNC_EN
  // A framing error occurs when the close reason and the count disagree:
  //   - s_last arrives before slot 7, or
  //   - slot 7 arrives without s_last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= load && (at_end ^ last_in);
    end
  end
`endif

  assign m_x0    = out_x[0];
  assign m_x1    = out_x[1];
  assign m_x2    = out_x[2];
  assign m_x3    = out_x[3];
  assign m_x4    = out_x[4];
  assign m_x5    = out_x[5];
  assign m_x6    = out_x[6];
  assign m_x7    = out_x[7];
  assign dbg_idx = idx;

endmodule

// File: tb/tb_fft_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_packer
//
// Self-checking bench for fft_frame_packer. The counter wrap is exercised
// with CNT_W = 4. The reference model keeps:
//   - a queue of accepted samples for the frame being filled,
//   - a queue of complete frames not yet taken by the FFT side.
// Compile with FRAME_SYNC_EN defined to cover the s_last / frame_err feature.
// ---------------------------------------------------------------------------
module tb_fft_frame_packer;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int FW     = 8 * DATA_W;
`ifdef FRAME_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_x0, m_x1, m_x2, m_x3, m_x4, m_x5, m_x6, m_x7;
  logic [CNT_W-1:0]  frame_cnt;
  logic [2:0]        dbg_idx;
`ifdef FRAME_SYNC_EN
  logic              s_last;
  logic              frame_err;
`endif

  fft_frame_packer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
`ifdef FRAME_SYNC_EN
    .s_last    (s_last),
`endif
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_x0      (m_x0),
    .m_x1      (m_x1),
    .m_x2      (m_x2),
    .m_x3      (m_x3),
    .m_x4      (m_x4),
    .m_x5      (m_x5),
    .m_x6      (m_x6),
    .m_x7      (m_x7),
    .frame_cnt (frame_cnt),
`ifdef FRAME_SYNC_EN
    .frame_err (frame_err),
`endif
    .dbg_idx   (dbg_idx)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [FW-1:0]     exp_q[$];   // frames produced, not yet taken
  logic [DATA_W-1:0] cur_q[$];   // samples of the frame being filled
  int                exp_cnt;
  logic              exp_err;
  logic              last_s_ready;
  int                checks = 0;
  int                errors = 0;

  function automatic logic [FW-1:0] out_frame();
    return {m_x7, m_x6, m_x5, m_x4, m_x3, m_x2, m_x1, m_x0};
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive inputs at the falling edge, then:
  //   - check s_ready against the model,
  //   - advance the model through the rising edge,
  //   - check the registered outputs 1 time unit later.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic mr);
    logic          acc;
    logic          xfer;
    logic          completes;
    logic          exp_ready;
    logic [FW-1:0] f;
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    m_ready = mr;
`ifdef FRAME_SYNC_EN
    s_last  = l;
`endif
    #1;
    // A sample finishing a frame cannot enter while an untaken frame waits.
    completes    = (cur_q.size() == 7) || (SYNC && l);
    exp_ready    = !(completes && exp_q.size() != 0 && !mr);
    last_s_ready = s_ready;
    chk("s_ready", {63'd0, s_ready}, {63'd0, exp_ready});
    acc     = v && exp_ready;
    xfer    = (exp_q.size() != 0) && mr;
    exp_err = 1'b0;
    if (xfer) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (acc) begin
      if (SYNC) exp_err = ((cur_q.size() == 7) != l);
      cur_q.push_back(d);
      if (cur_q.size() == 8 || (SYNC && l)) begin
        f = '0;
        for (int i = 0; i < cur_q.size(); i++) f[i*DATA_W +: DATA_W] = cur_q[i];
        exp_q.push_back(f);
        cur_q.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("m_valid", {63'd0, m_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("frame", out_frame(), exp_q[0]);
    chk("frame_cnt", {60'd0, frame_cnt}, {60'd0, exp_cnt[CNT_W-1:0]});
`ifdef FRAME_SYNC_EN
    chk("frame_err", {63'd0, frame_err}, {63'd0, exp_err});
`endif
  endtask

  // Asynchronous reset, asserted away from any clock edge. Checks that
  // every output clears immediately, then releases at a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_cnt", {60'd0, frame_cnt}, 64'd0);
    chk("rst_frame", out_frame(), 64'd0);
    chk("rst_idx", {61'd0, dbg_idx}, 64'd0);
`ifdef FRAME_SYNC_EN
    chk("rst_err", {63'd0, frame_err}, 64'd0);
`endif
    exp_q.delete();
    cur_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              mr;
    logic              exp_sr;
    logic              exp_mv;
    logic [DATA_W-1:0] exp_x0;
    logic [DATA_W-1:0] exp_x7;
    int                exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef FRAME_SYNC_EN
    s_last  = 1'b0;
`endif
    exp_cnt = 0;
    exp_err = 1'b0;
    apply_reset();

    // Stream 1..8 with m_ready high: frame visible right after the 8th edge.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{v: 1'b1, d: DATA_W'(i + 1), mr: 1'b1, exp_sr: 1'b1,
                  exp_mv: (i == 7), exp_x0: 8'd1, exp_x7: 8'd8, exp_cnt: 0};
    end
    vecs[8] = '{v: 1'b0, d: 8'd0, mr: 1'b1, exp_sr: 1'b1,
                exp_mv: 1'b0, exp_x0: 8'd0, exp_x7: 8'd0, exp_cnt: 1};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].d, 1'b0, vecs[i].mr);
      chk("vec_s_ready", {63'd0, last_s_ready}, {63'd0, vecs[i].exp_sr});
      chk("vec_m_valid", {63'd0, m_valid}, {63'd0, vecs[i].exp_mv});
      if (vecs[i].exp_mv) begin
        chk("vec_x0", {56'd0, m_x0}, {56'd0, vecs[i].exp_x0});
        chk("vec_x7", {56'd0, m_x7}, {56'd0, vecs[i].exp_x7});
      end
      chk("vec_cnt", {60'd0, frame_cnt}, 64'(vecs[i].exp_cnt));
    end

    // Downstream stall: frame A held while slots 0..6 of frame B still
    // fill. The 8th sample of B waits until A drains on the same edge.
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(11 + i), 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, DATA_W'(21 + i), 1'b0, 1'b0);
    chk("stall_x0_held", {56'd0, m_x0}, 64'd11);
    step(1'b1, 8'd28, 1'b0, 1'b0);
    chk("stall_s_ready_low", {63'd0, last_s_ready}, 64'd0);
    step(1'b1, 8'd28, 1'b0, 1'b1);
    chk("swap_m_valid", {63'd0, m_valid}, 64'd1);
    chk("swap_x0", {56'd0, m_x0}, 64'd21);
    chk("swap_x7", {56'd0, m_x7}, 64'd28);
    chk("swap_cnt", {60'd0, frame_cnt}, 64'd2);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Continuous signed stream -8..-1 then 0..7, no bubbles.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DATA_W'(i - 8), 1'b0, 1'b1);
      chk("cont_s_ready", {63'd0, last_s_ready}, 64'd1);
      if (i == 7) begin
        chk("neg_x0", {56'd0, m_x0}, 64'h00F8);
        chk("neg_x7", {56'd0, m_x7}, 64'h00FF);
      end
      if (i == 15) begin
        chk("pos_x0", {56'd0, m_x0}, 64'd0);
        chk("pos_x7", {56'd0, m_x7}, 64'd7);
      end
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Reset mid-frame with a frame pending; the next frame must be clean.
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(50 + i), 1'b0, 1'b0);
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(60 + i), 1'b0, 1'b1);
    chk("post_rst_x0", {56'd0, m_x0}, 64'd60);
    chk("post_rst_x6", {56'd0, m_x6}, 64'd66);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Counter wrap: 2^CNT_W frames bring frame_cnt back to zero.
    apply_reset();
    for (int i = 0; i < 8 * 16; i++) step(1'b1, DATA_W'($urandom), 1'b1, 1'b1);
    chk("wrap_pre", {60'd0, frame_cnt}, 64'd15);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("wrap_zero", {60'd0, frame_cnt}, 64'd0);

`ifdef FRAME_SYNC_EN
    // Early close: 5,6,7 with s_last on the 3rd sample.
    apply_reset();
    step(1'b1, 8'd5, 1'b0, 1'b1);
    step(1'b1, 8'd6, 1'b0, 1'b1);
    step(1'b1, 8'd7, 1'b1, 1'b1);
    chk("sync_frame", out_frame(), 64'h0000_0000_0007_0605);
    chk("sync_err", {63'd0, frame_err}, 64'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("sync_err_pulse", {63'd0, frame_err}, 64'd0);
    // Properly terminated frame: no error.
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(70 + i), (i == 7), 1'b1);
    chk("sync_ok_err", {63'd0, frame_err}, 64'd0);
    chk("sync_ok_x7", {56'd0, m_x7}, 64'd77);
    // Missing s_last on the 8th sample.
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(80 + i), 1'b0, 1'b1);
    chk("sync_miss_err", {63'd0, frame_err}, 64'd1);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, DATA_W'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
